// File: rtl/param_cache.sv
// Direct-mapped, write-through CPU cache with configurable line geometry,
// optional write-allocate and saturating hit/miss statistics.
module param_cache #(
  parameter int WORD_W         = 16,
  parameter int LINES          = 4,
  parameter int WORDS_PER_LINE = 4,
  parameter int WRITE_ALLOCATE = 0,
  parameter int CNT_W          = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             req_valid,
  input  logic                             req_write,
  input  logic [WORD_W-1:0]                req_addr,
  input  logic [WORD_W-1:0]                req_wdata,
  input  logic                             flush,
  output logic                             req_ready,
  output logic                             resp_valid,
  output logic [WORD_W-1:0]                resp_rdata,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [WORD_W-1:0]                mem_addr,
  output logic [WORD_W-1:0]                mem_wdata,
  input  logic [WORD_W*WORDS_PER_LINE-1:0] mem_rdata,
  input  logic                             mem_ack,
  output logic [CNT_W-1:0]                 hit_count,
  output logic [CNT_W-1:0]                 miss_count
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = WORD_W - OFF_W - IDX_W;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;

  state_t                  state;
  logic [LINES-1:0]        valid_q;
  logic [TAG_W-1:0]        tag_q  [LINES];
  logic [WORD_W-1:0]       data_q [LINES][WORDS_PER_LINE];
  logic [WORD_W-1:0]       addr_q;
  logic [WORD_W-1:0]       wdata_q;
  logic                    write_q;

  logic [OFF_W-1:0]        req_off, off_q;
  logic [IDX_W-1:0]        req_idx, idx_q;
  logic [TAG_W-1:0]        req_tag, tag_of_q;
  logic                    hit;
  logic                    accept;
  logic                    fill_done;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Word 0 of a fill line sits in the most significant slice.
  function automatic logic [WORD_W-1:0] line_word(
    input logic [WORD_W*WORDS_PER_LINE-1:0] line,
    input logic [OFF_W-1:0]                 off
  );
    logic [WORD_W-1:0] w;
    w = '0;
    for (int i = 0; i < WORDS_PER_LINE; i++)
      if (off == i[OFF_W-1:0])
        w = line[(WORDS_PER_LINE-1-i)*WORD_W +: WORD_W];
    return w;
  endfunction

  assign req_off   = req_addr[OFF_W-1:0];
  assign req_idx   = req_addr[OFF_W +: IDX_W];
  assign req_tag   = req_addr[WORD_W-1:OFF_W+IDX_W];
  assign off_q     = addr_q[OFF_W-1:0];
  assign idx_q     = addr_q[OFF_W +: IDX_W];
  assign tag_of_q  = addr_q[WORD_W-1:OFF_W+IDX_W];

  assign req_ready = (state == IDLE) && !flush;
  assign accept    = req_ready && req_valid;
  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign fill_done = (state == FILL) && mem_ack;

  // Fills fetch the whole line; write-through stores target the exact word.
  assign mem_addr  = mem_we ? addr_q : {addr_q[WORD_W-1:OFF_W], {OFF_W{1'b0}}};
  assign mem_wdata = wdata_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      valid_q    <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      resp_valid <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) begin
            valid_q <= '0;
          end else if (req_valid) begin
            if (hit) hit_count  <= sat_inc(hit_count);
            else     miss_count <= sat_inc(miss_count);
            if (!req_write && hit) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else if (!req_write || (!hit && WRITE_ALLOCATE != 0)) begin
              state   <= FILL;
              mem_req <= 1'b1;
              mem_we  <= 1'b0;
            end else begin
              state   <= WRITE;
              mem_req <= 1'b1;
              mem_we  <= 1'b1;
            end
          end
        end
        FILL: begin
          if (mem_ack) begin
            valid_q[idx_q] <= 1'b1;
            if (write_q) begin
              state  <= WRITE;
              mem_we <= 1'b1;
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
              mem_req    <= 1'b0;
            end
          end
        end
        WRITE: begin
          if (mem_ack) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Data-side storage carries no reset; stale contents are masked by valid_q.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q     <= req_addr;
      wdata_q    <= req_wdata;
      write_q    <= req_write;
      resp_rdata <= data_q[req_idx][req_off];
      if (req_write && hit)
        data_q[req_idx][req_off] <= req_wdata;
    end
    if (fill_done) begin
      tag_q[idx_q] <= tag_of_q;
      for (int i = 0; i < WORDS_PER_LINE; i++)
        data_q[idx_q][i] <= (write_q && off_q == i[OFF_W-1:0]) ?
                            wdata_q : line_word(mem_rdata, i[OFF_W-1:0]);
      resp_rdata <= line_word(mem_rdata, off_q);
    end
  end

endmodule

// File: tb/tb_param_cache.sv
// Bench for param_cache: two instances (default, and CNT_W=2 with write-allocate)
// checked against a coherent-memory reference with explicit line valid/tag tracking.
module tb_param_cache;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid [2];
  logic        req_write [2];
  logic [15:0] req_addr  [2];
  logic [15:0] req_wdata [2];
  logic        flush     [2];
  logic        req_ready [2];
  logic        resp_valid[2];
  logic [15:0] resp_rdata[2];
  logic        mem_req   [2];
  logic        mem_we    [2];
  logic [15:0] mem_addr  [2];
  logic [15:0] mem_wdata [2];
  logic [63:0] mem_rdata [2];
  logic        mem_ack   [2];
  logic [15:0] hc0, mc0;
  logic [1:0]  hc1, mc1;
  logic [15:0] hit_cnt [2];
  logic [15:0] miss_cnt[2];

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: memory image plus which line holds which tag.
  logic [15:0] mem_ovr[int];
  bit          m_valid[2][4];
  int          m_tag  [2][4];
  int          m_hits [2];
  int          m_miss [2];
  int          cnt_max[2] = '{65535, 3};
  bit          wa     [2] = '{1'b0, 1'b1};

  always #5 clk = ~clk;

  assign hit_cnt[0]  = hc0;
  assign miss_cnt[0] = mc0;
  assign hit_cnt[1]  = {14'd0, hc1};
  assign miss_cnt[1] = {14'd0, mc1};

  param_cache dut0 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .flush(flush[0]),
    .req_ready(req_ready[0]), .resp_valid(resp_valid[0]),
    .resp_rdata(resp_rdata[0]), .mem_req(mem_req[0]), .mem_we(mem_we[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .mem_ack(mem_ack[0]),
    .hit_count(hc0), .miss_count(mc0)
  );

  param_cache #(.CNT_W(2), .WRITE_ALLOCATE(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .flush(flush[1]),
    .req_ready(req_ready[1]), .resp_valid(resp_valid[1]),
    .resp_rdata(resp_rdata[1]), .mem_req(mem_req[1]), .mem_we(mem_we[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .mem_ack(mem_ack[1]),
    .hit_count(hc1), .miss_count(mc1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_rd(input int d, input int a);
    logic [31:0] h;
    int key;
    key = d * 65536 + a;
    if (mem_ovr.exists(key)) return mem_ovr[key];
    h = a * 40503 + 7919 + d * 131;
    return h[15:0] ^ h[31:16];
  endfunction

  function automatic logic [63:0] line_of(input int d, input int a);
    int b;
    b = a & 16'hFFFC;
    return {mem_rd(d, b), mem_rd(d, b + 1), mem_rd(d, b + 2), mem_rd(d, b + 3)};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int l = 0; l < 4; l++) m_valid[d][l] = 1'b0;
      m_hits[d] = 0;
      m_miss[d] = 0;
    end
  endtask

  task automatic check_counts(input int d);
    chk($sformatf("hit_count%0d", d),  hit_cnt[d],  m_hits[d]);
    chk($sformatf("miss_count%0d", d), miss_cnt[d], m_miss[d]);
  endtask

  // One memory handshake: verify the request, stall, then acknowledge.
  task automatic mem_phase(input int d, input bit we, input logic [15:0] a,
                           input logic [15:0] wd, input int stall);
    chk("mem_req", mem_req[d], 1'b1);
    chk("mem_we", mem_we[d], we);
    chk("mem_addr", mem_addr[d], we ? a : (a & 16'hFFFC));
    if (we) chk("mem_wdata", mem_wdata[d], wd);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk("stall_req", mem_req[d], 1'b1);
      chk("stall_resp", resp_valid[d], 1'b0);
    end
    mem_ack[d]   = 1'b1;
    mem_rdata[d] = line_of(d, a);
    @(posedge clk); #1;
    mem_ack[d]   = 1'b0;
    mem_rdata[d] = {$urandom, $urandom};
    if (we) mem_ovr[d * 65536 + a] = wd;
  endtask

  task automatic cpu_req(input int d, input bit wr, input logic [15:0] a,
                         input logic [15:0] wd, input int stall);
    int  idx, tg;
    bit  hit, fill;
    idx  = (a >> 2) & 3;
    tg   = a >> 4;
    hit  = m_valid[d][idx] && m_tag[d][idx] == tg;
    fill = !hit && (!wr || wa[d]);
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    #1 chk("req_ready", req_ready[d], 1'b1);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    if (hit) m_hits[d] = (m_hits[d] < cnt_max[d]) ? m_hits[d] + 1 : m_hits[d];
    else     m_miss[d] = (m_miss[d] < cnt_max[d]) ? m_miss[d] + 1 : m_miss[d];
    if (!hit || wr) begin
      if (fill) begin
        mem_phase(d, 1'b0, a, wd, stall);
        m_valid[d][idx] = 1'b1;
        m_tag[d][idx]   = tg;
      end
      if (wr) mem_phase(d, 1'b1, a, wd, stall);
    end
    chk("resp_valid", resp_valid[d], 1'b1);
    chk("resp_no_mem", mem_req[d], 1'b0);
    if (!wr) chk($sformatf("rdata@%0h", a), resp_rdata[d], mem_rd(d, a));
    @(posedge clk); #1;
    chk("resp_pulse", resp_valid[d], 1'b0);
    check_counts(d);
  endtask

  task automatic do_flush(input int d, input bit with_req);
    @(negedge clk);
    flush[d]     = 1'b1;
    req_valid[d] = with_req;
    req_write[d] = 1'b0;
    req_addr[d]  = 16'($urandom);
    #1 chk("flush_ready", req_ready[d], 1'b0);
    @(posedge clk); #1;
    flush[d]     = 1'b0;
    req_valid[d] = 1'b0;
    for (int l = 0; l < 4; l++) m_valid[d][l] = 1'b0;
    @(posedge clk); #1;
    chk("flush_resp", resp_valid[d], 1'b0);
    chk("flush_mem", mem_req[d], 1'b0);
    check_counts(d);
  endtask

  task automatic stray_ack(input int d);
    @(negedge clk);
    mem_ack[d] = 1'b1;
    @(posedge clk); #1;
    mem_ack[d] = 1'b0;
    chk("stray_req", mem_req[d], 1'b0);
    chk("stray_resp", resp_valid[d], 1'b0);
    check_counts(d);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: got 1 expected 0");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 0; req_write[d] = 0; req_addr[d] = 0; req_wdata[d] = 0;
      flush[d] = 0; mem_ack[d] = 0; mem_rdata[d] = 0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", req_ready[d], 1'b1);
      chk("rst_resp", resp_valid[d], 1'b0);
      chk("rst_mem_req", mem_req[d], 1'b0);
      chk("rst_mem_we", mem_we[d], 1'b0);
      check_counts(d);
    end
    reset_n = 1'b1;

    // Known line at 0x0010 for the directed sequence.
    mem_ovr[16'h10] = 16'hAAAA; mem_ovr[16'h11] = 16'hBBBB;
    mem_ovr[16'h12] = 16'hCCCC; mem_ovr[16'h13] = 16'hDDDD;
    cpu_req(0, 0, 16'h0010, 0, 3);
    chk("cold_rdata", resp_rdata[0], 16'hAAAA);
    chk("cold_miss", miss_cnt[0], 1);
    cpu_req(0, 0, 16'h0012, 0, 0);
    chk("hit_rdata", resp_rdata[0], 16'hCCCC);
    chk("first_hit", hit_cnt[0], 1);
    cpu_req(0, 1, 16'h0011, 16'h1234, 2);
    cpu_req(0, 0, 16'h0011, 0, 0);
    chk("wr_hit_rdata", resp_rdata[0], 16'h1234);
    cpu_req(0, 1, 16'h0050, 16'h5555, 1);
    cpu_req(0, 0, 16'h0050, 0, 1);
    chk("noalloc_miss", miss_cnt[0], 3);
    stray_ack(0);
    do_flush(0, 1'b1);
    cpu_req(0, 0, 16'h0010, 0, 2);
    chk("post_flush_miss", miss_cnt[0], 4);

    // Reset in the middle of a fill abandons it; a late ack must be ignored.
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 16'h0090;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("abort_fill_req", mem_req[0], 1'b1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_req_drop", mem_req[0], 1'b0);
    reset_n = 1'b1;
    mem_ack[0] = 1'b1;
    mem_rdata[0] = line_of(0, 16'h0090);
    @(posedge clk); #1;
    mem_ack[0] = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("late_ack_req", mem_req[0], 1'b0);
    chk("late_ack_resp", resp_valid[0], 1'b0);
    check_counts(0);
    check_counts(1);
    cpu_req(0, 0, 16'h0090, 0, 0);

    // Saturating 2-bit counter and write-allocate merge on the second instance.
    cpu_req(1, 0, 16'h0010, 0, 1);
    for (int k = 0; k < 5; k++) cpu_req(1, 0, 16'(16'h0010 + (k % 4)), 0, 0);
    chk("hit_saturate", hit_cnt[1], 3);
    cpu_req(1, 1, 16'h0104, 16'hBEEF, 2);
    cpu_req(1, 0, 16'h0104, 0, 0);
    chk("alloc_rdata", resp_rdata[1], 16'hBEEF);
    cpu_req(1, 0, 16'h0105, 0, 0);

    // Randomized traffic over a small tag set to mix hits, misses and evictions.
    for (int d = 0; d < 2; d++) begin
      for (int t = 0; t < 150; t++) begin
        int r;
        logic [15:0] a;
        r = $urandom_range(0, 39);
        a = 16'(($urandom_range(0, 7) << 4) | $urandom_range(0, 15));
        if (r == 0)      do_flush(d, 1'($urandom_range(0, 1)));
        else if (r == 1) stray_ack(d);
        else cpu_req(d, ($urandom_range(0, 2) == 0), a, 16'($urandom),
                     $urandom_range(0, 4));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
